// File: rtl/mux_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with per-frame shadow capture and
// blanking dead time. Optional PWM brightness control enabled by defining DISP_BRIGHTNESS_EN.
module mux_display_scanner #(
    parameter int unsigned     DISP        = 8,
    parameter int unsigned     REFRESH_DIV = 100000,
    parameter int unsigned     CNT_W       = 17,
    parameter int unsigned     DEAD_CYCLES = 16,
    parameter logic [DISP-1:0] BLANK_SEG   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
`ifdef DISP_BRIGHTNESS_EN
    input  logic [3:0]      brightness,
`endif
    input  logic [DISP-1:0] seg_seconds_units,
    input  logic [DISP-1:0] seg_seconds_tens,
    input  logic [DISP-1:0] seg_minutes_units,
    input  logic [DISP-1:0] seg_minutes_tens,
    output logic [DISP-1:0] seg_out,
    output logic [3:0]      an_out,
    output logic            frame_done
);

    typedef enum logic [1:0] {StIdle, StDead, StShow} phase_e;

    phase_e                 phase;
    logic                   slot_end;
    logic                   wrap;
    logic                   lit;
    logic [CNT_W-1:0]       slot_cnt_d, slot_cnt_q;
    logic [1:0]             idx_d, idx_q;
    logic [3:0][DISP-1:0]   shadow_d, shadow_q;
    logic                   load_pending_d, load_pending_q;
    logic [DISP-1:0]        seg_d, seg_q;
    logic [3:0]             an_d, an_q;
    logic                   frame_done_d, frame_done_q;
`ifdef DISP_BRIGHTNESS_EN
    logic [3:0]             pwm_cnt_d, pwm_cnt_q;
    logic [3:0]             brightness_d, brightness_q;
`endif

    always_comb begin
        slot_cnt_d     = slot_cnt_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        load_pending_d = load_pending_q;
        seg_d          = BLANK_SEG;
        an_d           = 4'b1111;
        lit            = 1'b1;
`ifdef DISP_BRIGHTNESS_EN
        pwm_cnt_d      = pwm_cnt_q;
        brightness_d   = brightness_q;
        lit            = pwm_cnt_q < brightness_q;
`endif

        slot_end = slot_cnt_q == CNT_W'(REFRESH_DIV - 1);
        wrap     = en && slot_end && (idx_q == 2'd3);

        if (!en) begin
            phase = StIdle;
        end else if (slot_cnt_q < CNT_W'(DEAD_CYCLES)) begin
            phase = StDead;
        end else begin
            phase = StShow;
        end

        if (en) begin
            if (slot_end) begin
                slot_cnt_d = '0;
                idx_d      = idx_q + 2'd1;
            end else begin
                slot_cnt_d = slot_cnt_q + CNT_W'(1);
            end
`ifdef DISP_BRIGHTNESS_EN
            pwm_cnt_d = pwm_cnt_q + 4'd1;
`endif
            // Shadows only change at a frame wrap (or the first enabled cycle after reset).
            if (load_pending_q || wrap) begin
                shadow_d       = {seg_minutes_tens, seg_minutes_units,
                                  seg_seconds_tens, seg_seconds_units};
                load_pending_d = 1'b0;
`ifdef DISP_BRIGHTNESS_EN
                brightness_d   = brightness;
`endif
            end
        end

        frame_done_d = wrap;

        unique case (phase)
            StShow: begin
                if (lit) begin
                    seg_d = shadow_q[idx_q];
                    an_d  = ~(4'b0001 << idx_q);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt_q     <= '0;
            idx_q          <= '0;
            shadow_q       <= {4{BLANK_SEG}};
            load_pending_q <= 1'b1;
            seg_q          <= BLANK_SEG;
            an_q           <= 4'b1111;
            frame_done_q   <= 1'b0;
`ifdef DISP_BRIGHTNESS_EN
            pwm_cnt_q      <= '0;
            brightness_q   <= 4'hF;
`endif
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            load_pending_q <= load_pending_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            frame_done_q   <= frame_done_d;
`ifdef DISP_BRIGHTNESS_EN
            pwm_cnt_q      <= pwm_cnt_d;
            brightness_q   <= brightness_d;
`endif
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule
